// File: rtl/hv_fault_mgr.sv
// HV fault manager: per-channel debounce, mask/class, sticky latching and a
// run/fault/recover/lockout FSM. Define HV_FLT_MGR_SNAPSHOT_EN for first-fault capture.
module hv_fault_mgr #(
    parameter int ERR_NUM   = 8,
    parameter int DBC_CYC   = 4,
    parameter int RCV_CYC   = 16,
    parameter int RETRY_MAX = 3,
    parameter int RETRY_W   = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [ERR_NUM-1:0] i_err_raw,
    input  logic [ERR_NUM-1:0] i_err_mask,
    input  logic [ERR_NUM-1:0] i_err_kill,
    input  logic [ERR_NUM-1:0] i_err_clr,
    input  logic               i_lock_clr,
    output logic [ERR_NUM-1:0] o_err_flt,
    output logic [ERR_NUM-1:0] o_err_sticky,
    output logic [ERR_NUM-1:0] o_first_err,
    output logic               o_pwm_en,
    output logic               o_intb_n,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic [2:0]         o_st
);

    // state | meaning
    // IDLE  | fault handling disabled
    // RUN   | normal operation, PWM enabled
    // FAULT | kill-class error active, PWM off
    // RCV   | errors gone, waiting out the recovery time
    // LOCK  | retry limit reached, waiting for i_lock_clr
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FAULT = 3'd2,
        ST_RCV   = 3'd3,
        ST_LOCK  = 3'd4
    } st_e;

    localparam int DW = (DBC_CYC > 1) ? $clog2(DBC_CYC) : 1;
    localparam int TW = $clog2(RCV_CYC + 1);
    localparam logic [DW-1:0]      DBC_TC    = DW'(DBC_CYC - 1);
    localparam logic [TW-1:0]      RCV_LD    = TW'(RCV_CYC);
    localparam logic [TW-1:0]      RUN_TC    = TW'(RCV_CYC - 1);
    localparam logic [TW-1:0]      TMR_ONE   = TW'(1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);
    localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

    logic [ERR_NUM-1:0] flt_q, flt_d;
    logic [DW-1:0]      dbc_q [ERR_NUM];
    logic [DW-1:0]      dbc_d [ERR_NUM];
    logic [ERR_NUM-1:0] sticky_q, sticky_d;
    logic [ERR_NUM-1:0] act;
    logic               kill;
    st_e                st_q, st_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               pwm_q, intb_q;

    always_comb begin
        flt_d = flt_q;
        for (int i = 0; i < ERR_NUM; i++) begin
            dbc_d[i] = '0;
            if (i_err_raw[i] != flt_q[i]) begin
                if (dbc_q[i] == DBC_TC) flt_d[i] = ~flt_q[i];
                else                    dbc_d[i] = dbc_q[i] + 1'b1;
            end
        end
    end

    assign act      = flt_q & ~i_err_mask;
    assign kill     = |(act & i_err_kill);
    // An active channel always wins over its clear pulse.
    assign sticky_d = act | (sticky_q & ~(i_err_clr & ~act));
    assign retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;

    always_comb begin
        st_d    = st_q;
        tmr_d   = tmr_q;
        retry_d = retry_q;
        case (st_q)
            ST_IDLE: begin
                if (i_en) begin
                    st_d  = ST_RUN;
                    tmr_d = '0;
                end
            end
            ST_RUN: begin
                if (!i_en) begin
                    st_d = ST_IDLE;
                end else if (kill) begin
                    st_d    = ST_FAULT;
                    retry_d = retry_inc;
                end else if (tmr_q == RUN_TC) begin
                    retry_d = '0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_FAULT: begin
                if (!i_en) begin
                    st_d = ST_IDLE;
                end else if (!kill) begin
                    if (retry_q >= RETRY_LIM) begin
                        st_d = ST_LOCK;
                    end else begin
                        st_d  = ST_RCV;
                        tmr_d = RCV_LD;
                    end
                end
            end
            ST_RCV: begin
                if (!i_en) begin
                    st_d = ST_IDLE;
                end else if (kill) begin
                    st_d    = ST_FAULT;
                    retry_d = retry_inc;
                end else if (tmr_q == TMR_ONE) begin
                    st_d  = ST_RUN;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_LOCK: begin
                if (i_lock_clr) begin
                    st_d    = ST_IDLE;
                    retry_d = '0;
                end
            end
            default: begin
                st_d  = ST_IDLE;
                tmr_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flt_q    <= '0;
            sticky_q <= '0;
            st_q     <= ST_IDLE;
            tmr_q    <= '0;
            retry_q  <= '0;
            pwm_q    <= 1'b0;
            intb_q   <= 1'b0;
            for (int i = 0; i < ERR_NUM; i++) dbc_q[i] <= '0;
        end else begin
            flt_q    <= flt_d;
            sticky_q <= sticky_d;
            st_q     <= st_d;
            tmr_q    <= tmr_d;
            retry_q  <= retry_d;
            pwm_q    <= (st_d == ST_RUN);
            intb_q   <= !((st_d == ST_FAULT) || (st_d == ST_LOCK) ||
                          (st_d == ST_IDLE) || (|sticky_d));
            for (int i = 0; i < ERR_NUM; i++) dbc_q[i] <= dbc_d[i];
        end
    end

`ifdef HV_FLT_MGR_SNAPSHOT_EN
    logic [ERR_NUM-1:0] first_q;
    logic               snap_cap, snap_clr;

    // Released by the lockout clear or by the clean-run retry reset.
    assign snap_cap = (st_q == ST_RUN) && i_en && kill;
    assign snap_clr = ((st_q == ST_RUN) && i_en && !kill && (tmr_q == RUN_TC)) ||
                      ((st_q == ST_LOCK) && i_lock_clr);

    always_ff @(posedge i_clk) begin
        if (i_rst)                         first_q <= '0;
        else if (snap_clr)                 first_q <= '0;
        else if (snap_cap && first_q == '0) first_q <= act & i_err_kill;
    end

    assign o_first_err = first_q;
`else
    assign o_first_err = '0;
`endif

    assign o_err_flt    = flt_q;
    assign o_err_sticky = sticky_q;
    assign o_pwm_en     = pwm_q;
    assign o_intb_n     = intb_q;
    assign o_retry_cnt  = retry_q;
    assign o_st         = st_q;

endmodule

// File: tb/tb_hv_fault_mgr.sv
// Bench for hv_fault_mgr: directed table, hand-written corner sequences and
// random stimulus, all checked against a cycle model derived from the behaviour rules.
module tb_hv_fault_mgr;

    localparam int N       = 8;
    localparam int DBC     = 4;
    localparam int RCV     = 16;
    localparam int RMAX    = 3;
    localparam int RSAT    = 7;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_en = 1'b0;
    logic [N-1:0] i_err_raw = '0, i_err_mask = '0, i_err_kill = '1, i_err_clr = '0;
    logic         i_lock_clr = 1'b0;
    logic [N-1:0] o_err_flt, o_err_sticky, o_first_err;
    logic         o_pwm_en, o_intb_n;
    logic [2:0]   o_retry_cnt;
    logic [2:0]   o_st;

    hv_fault_mgr dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
        .i_err_raw(i_err_raw), .i_err_mask(i_err_mask), .i_err_kill(i_err_kill),
        .i_err_clr(i_err_clr), .i_lock_clr(i_lock_clr),
        .o_err_flt(o_err_flt), .o_err_sticky(o_err_sticky), .o_first_err(o_first_err),
        .o_pwm_en(o_pwm_en), .o_intb_n(o_intb_n), .o_retry_cnt(o_retry_cnt), .o_st(o_st)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: 0 IDLE, 1 RUN, 2 FAULT, 3 RCV, 4 LOCK
    int         m_st = 0;
    logic [N-1:0] m_flt = '0, m_sticky = '0, m_first = '0;
    int         m_diff [N];
    int         m_retry = 0, m_clean = 0, m_left = 0;
    bit         m_intb = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", nm, $time, a, e);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= RSAT) ? RSAT : v + 1;
    endfunction

    task automatic model_step();
        logic [N-1:0] act, ns;
        bit kl;
        if (i_rst) begin
            m_st = 0; m_flt = '0; m_sticky = '0; m_first = '0;
            m_retry = 0; m_clean = 0; m_left = 0; m_intb = 0;
            foreach (m_diff[i]) m_diff[i] = 0;
            return;
        end
        act = m_flt & ~i_err_mask;
        kl  = (act & i_err_kill) != 0;
        for (int i = 0; i < N; i++) begin
            if (act[i])          ns[i] = 1'b1;
            else if (i_err_clr[i]) ns[i] = 1'b0;
            else                 ns[i] = m_sticky[i];
        end
        m_sticky = ns;
        for (int i = 0; i < N; i++) begin
            if (i_err_raw[i] != m_flt[i]) begin
                m_diff[i]++;
                if (m_diff[i] == DBC) begin
                    m_flt[i]  = ~m_flt[i];
                    m_diff[i] = 0;
                end
            end else begin
                m_diff[i] = 0;
            end
        end
        case (m_st)
            0: if (i_en) begin m_st = 1; m_clean = 0; end
            1: if (!i_en) m_st = 0;
               else if (kl) begin
                   m_st = 2; m_retry = sat_inc(m_retry);
`ifdef HV_FLT_MGR_SNAPSHOT_EN
                   if (m_first == 0) m_first = act & i_err_kill;
`endif
               end else begin
                   m_clean++;
                   if (m_clean == RCV) begin
                       m_clean = 0; m_retry = 0; m_first = '0;
                   end
               end
            2: if (!i_en) m_st = 0;
               else if (!kl) begin
                   if (m_retry >= RMAX) m_st = 4;
                   else begin m_st = 3; m_left = RCV; end
               end
            3: if (!i_en) m_st = 0;
               else if (kl) begin m_st = 2; m_retry = sat_inc(m_retry); end
               else if (m_left == 1) begin m_st = 1; m_clean = 0; end
               else m_left--;
            4: if (i_lock_clr) begin m_st = 0; m_retry = 0; m_first = '0; end
            default: m_st = 0;
        endcase
        m_intb = !(m_st == 0 || m_st == 2 || m_st == 4 || m_sticky != 0);
    endtask

    task automatic model_cmp();
        chk("st",     32'(o_st),         32'(m_st));
        chk("pwm",    32'(o_pwm_en),     32'(m_st == 1));
        chk("intb",   32'(o_intb_n),     32'(m_intb));
        chk("retry",  32'(o_retry_cnt),  32'(m_retry));
        chk("flt",    32'(o_err_flt),    32'(m_flt));
        chk("sticky", 32'(o_err_sticky), 32'(m_sticky));
        chk("first",  32'(o_first_err),  32'(m_first));
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            model_step();
            #1;
            model_cmp();
        end
    endtask

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] clr;
        logic         en;
        int           n;
        logic [2:0]   st;
        logic         pwm;
        logic         intb;
        logic [2:0]   retry;
        logic [N-1:0] flt;
        logic [N-1:0] sticky;
    } vec_t;

    vec_t tbl [14];

    initial begin
        foreach (m_diff[i]) m_diff[i] = 0;
        //          raw    clr    en n    st   pwm intb retry flt    sticky
        tbl[0]  = '{8'h00, 8'h00, 1, 1,  3'd1, 1, 1, 3'd0, 8'h00, 8'h00};
        tbl[1]  = '{8'h01, 8'h00, 1, 3,  3'd1, 1, 1, 3'd0, 8'h00, 8'h00};
        tbl[2]  = '{8'h00, 8'h00, 1, 1,  3'd1, 1, 1, 3'd0, 8'h00, 8'h00};
        tbl[3]  = '{8'h01, 8'h00, 1, 4,  3'd1, 1, 1, 3'd0, 8'h01, 8'h00};
        tbl[4]  = '{8'h01, 8'h00, 1, 1,  3'd2, 0, 0, 3'd1, 8'h01, 8'h01};
        tbl[5]  = '{8'h00, 8'h00, 1, 4,  3'd2, 0, 0, 3'd1, 8'h00, 8'h01};
        tbl[6]  = '{8'h00, 8'h00, 1, 1,  3'd3, 0, 0, 3'd1, 8'h00, 8'h01};
        tbl[7]  = '{8'h00, 8'h01, 1, 1,  3'd3, 0, 1, 3'd1, 8'h00, 8'h00};
        tbl[8]  = '{8'h00, 8'h00, 1, 14, 3'd3, 0, 1, 3'd1, 8'h00, 8'h00};
        tbl[9]  = '{8'h00, 8'h00, 1, 1,  3'd1, 1, 1, 3'd1, 8'h00, 8'h00};
        tbl[10] = '{8'h00, 8'h00, 1, 15, 3'd1, 1, 1, 3'd1, 8'h00, 8'h00};
        tbl[11] = '{8'h00, 8'h00, 1, 1,  3'd1, 1, 1, 3'd0, 8'h00, 8'h00};
        tbl[12] = '{8'h00, 8'h00, 0, 1,  3'd0, 0, 0, 3'd0, 8'h00, 8'h00};
        tbl[13] = '{8'h00, 8'h00, 1, 1,  3'd1, 1, 1, 3'd0, 8'h00, 8'h00};

        // reset
        i_rst = 1'b1;
        cyc(2);
        chk("rst_st",   32'(o_st), 0);
        chk("rst_pwm",  32'(o_pwm_en), 0);
        chk("rst_intb", 32'(o_intb_n), 0);
        chk("rst_flt",  32'(o_err_flt), 0);
        i_rst = 1'b0;

        // directed table: debounce, fault, recovery, clean-run retry clear
        for (int r = 0; r < 14; r++) begin
            i_err_raw = tbl[r].raw;
            i_err_clr = tbl[r].clr;
            i_en      = tbl[r].en;
            cyc(tbl[r].n);
            chk($sformatf("t%0d_st", r),     32'(o_st),         32'(tbl[r].st));
            chk($sformatf("t%0d_pwm", r),    32'(o_pwm_en),     32'(tbl[r].pwm));
            chk($sformatf("t%0d_intb", r),   32'(o_intb_n),     32'(tbl[r].intb));
            chk($sformatf("t%0d_retry", r),  32'(o_retry_cnt),  32'(tbl[r].retry));
            chk($sformatf("t%0d_flt", r),    32'(o_err_flt),    32'(tbl[r].flt));
            chk($sformatf("t%0d_sticky", r), 32'(o_err_sticky), 32'(tbl[r].sticky));
        end
        i_err_clr = '0;

        // lockout after three kill faults, with snapshot
        i_err_raw = 8'h18; cyc(6);
        chk("lk_f1_st", 32'(o_st), 2);
`ifdef HV_FLT_MGR_SNAPSHOT_EN
        chk("snap_first", 32'(o_first_err), 32'h18);
`else
        chk("snap_off", 32'(o_first_err), 0);
`endif
        i_err_raw = 8'h00; cyc(5);
        chk("lk_rcv1", 32'(o_st), 3);
        i_err_raw = 8'h01; cyc(6);
        chk("lk_f2_retry", 32'(o_retry_cnt), 2);
        i_err_raw = 8'h00; cyc(5);
        i_err_raw = 8'h01; cyc(6);
        i_err_raw = 8'h00; cyc(5);
        chk("lk_st", 32'(o_st), 4);
        chk("lk_pwm", 32'(o_pwm_en), 0);
        chk("lk_retry", 32'(o_retry_cnt), 3);
        i_en = 1'b0; cyc(3);
        i_en = 1'b1; cyc(3);
        chk("lk_hold", 32'(o_st), 4);
`ifdef HV_FLT_MGR_SNAPSHOT_EN
        chk("snap_keep", 32'(o_first_err), 32'h18);
`endif
        i_lock_clr = 1'b1; cyc(1);
        i_lock_clr = 1'b0;
        chk("lk_clr_st", 32'(o_st), 0);
        chk("lk_clr_retry", 32'(o_retry_cnt), 0);
        chk("snap_clr", 32'(o_first_err), 0);
        cyc(1);
        chk("lk_run", 32'(o_st), 1);
        i_err_clr = '1; cyc(1);
        i_err_clr = '0; cyc(1);
        chk("lk_intb", 32'(o_intb_n), 1);

        // mask and report-only class
        i_err_mask = 8'h20; i_err_raw = 8'h20; cyc(8);
        chk("mask_sticky", 32'(o_err_sticky), 0);
        chk("mask_st", 32'(o_st), 1);
        i_err_kill = 8'hBF; i_err_raw = 8'h60; cyc(8);
        chk("rep_sticky", 32'(o_err_sticky[6]), 1);
        chk("rep_intb", 32'(o_intb_n), 0);
        chk("rep_pwm", 32'(o_pwm_en), 1);
        i_err_clr = 8'h40; cyc(1);
        i_err_clr = '0;
        chk("rep_clr_blocked", 32'(o_err_sticky[6]), 1);
        i_err_raw = 8'h00; cyc(5);
        i_err_clr = 8'h40; cyc(1);
        i_err_clr = '0; i_err_mask = '0; i_err_kill = '1; cyc(1);
        chk("rep_released", 32'(o_intb_n), 1);

        // re-fault during recovery, disable in RCV, reset mid-FAULT
        i_err_raw = 8'h02; cyc(6);
        i_err_raw = 8'h00; cyc(5);
        cyc(5);
        i_err_raw = 8'h02; cyc(6);
        chk("rf_st", 32'(o_st), 2);
        chk("rf_retry", 32'(o_retry_cnt), 2);
        i_err_raw = 8'h00; cyc(5);
        chk("rf_rcv", 32'(o_st), 3);
        i_en = 1'b0; cyc(1);
        chk("rf_idle", 32'(o_st), 0);
        i_en = 1'b1;
        i_err_raw = 8'h02; cyc(7);
        chk("rst_mid_pre", 32'(o_st), 2);
        i_rst = 1'b1; cyc(1);
        chk("rstm_st", 32'(o_st), 0);
        chk("rstm_retry", 32'(o_retry_cnt), 0);
        chk("rstm_sticky", 32'(o_err_sticky), 0);
        chk("rstm_flt", 32'(o_err_flt), 0);
        chk("rstm_intb", 32'(o_intb_n), 0);
        i_rst = 1'b0; i_err_raw = '0;
        cyc(2);

        // randomized stimulus against the model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 9) == 0) i_err_raw = i_err_raw ^ N'(1 << $urandom_range(0, N-1));
            if ($urandom_range(0, 99) == 0) i_err_raw = N'($urandom);
            if ($urandom_range(0, 199) == 0) i_err_mask = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 199) == 0) i_err_kill = N'($urandom) | N'($urandom);
            i_err_clr  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            i_en       = ($urandom_range(0, 39) != 0);
            i_lock_clr = ($urandom_range(0, 19) == 0);
            i_rst      = ($urandom_range(0, 499) == 0);
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hv_fault_mgr.md
Name: hv_fault_mgr

Overview:
- Parametrised fault-handling FSM for the HV die; next generation of the HV control unit's fault handling.
- Takes N raw error lines and applies per-channel debounce, mask and class (PWM-kill vs report-only), plus sticky latching.
- Runs a run/fault/recover/lockout FSM with timed auto-recovery and a retry limit.
- Drives PWM enable and interrupt to the top-level control FSM, which asserts i_en while in NML/FAULT.

Parameters:
ERR_NUM, 8, number of error channels
DBC_CYC, 4, consecutive cycles raw must differ from filtered value before the filtered value toggles (>=1)
RCV_CYC, 16, recovery wait cycles; also the clean-run length that clears the retry count (>=1)
RETRY_MAX, 3, kill faults allowed before lockout (1..2^RETRY_W-1)
RETRY_W, 3, retry counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_en  in  1  fault handling enabled (top FSM in NML/FAULT)
i_err_raw  in  ERR_NUM  raw error lines
i_err_mask  in  ERR_NUM  1 = channel ignored for FSM/sticky
i_err_kill  in  ERR_NUM  1 = channel class kills PWM, 0 = report-only
i_err_clr  in  ERR_NUM  per-channel sticky clear pulse (W1C)
i_lock_clr  in  1  release lockout pulse
o_err_flt  out  ERR_NUM  debounced error levels
o_err_sticky  out  ERR_NUM  latched unmasked errors
o_first_err  out  ERR_NUM  first-fault snapshot (optional feature)
o_pwm_en  out  1  PWM enable
o_intb_n  out  1  interrupt, active-low
o_retry_cnt  out  RETRY_W  current retry count
o_st  out  3  FSM state: IDLE=0, RUN=1, FAULT=2, RCV=3, LOCK=4

Behaviour:
- Reset (i_rst=1 at posedge): state IDLE; all counters 0; o_err_flt=0, o_err_sticky=0, o_first_err=0, o_pwm_en=0, o_retry_cnt=0, o_intb_n=0.
- Debounce, per channel:
  - raw==flt -> counter 0.
  - Else counter+1; at the edge where counter==DBC_CYC-1, flt toggles and counter returns to 0.
  - A stable change is visible on o_err_flt exactly DBC_CYC edges after it is applied; a glitch shorter than DBC_CYC cycles is dropped.
- act = o_err_flt & ~i_err_mask; kill = |(act & i_err_kill).
- Sticky: set when act[i]=1; clear on i_err_clr[i] only if act[i]=0. Set wins over a simultaneous clear. Mask does not clear sticky.
- FSM (registered; all outputs registered from next state, one-cycle latency after the deciding input):
  - IDLE: i_en=1 -> RUN.
  - RUN: ~i_en -> IDLE; else kill -> FAULT with retry+1 (saturating at 2^RETRY_W-1).
    - While clean, the timer counts up; after RCV_CYC consecutive clean RUN cycles, retry clears to 0.
    - Timer resets on RUN entry.
  - FAULT: ~i_en -> IDLE; else ~kill and retry>=RETRY_MAX -> LOCK; else ~kill -> RCV, timer loaded RCV_CYC.
  - RCV: ~i_en -> IDLE; else kill -> FAULT with retry+1; else timer decrements; on the cycle it reads 1 -> RUN.
  - LOCK: ignores i_en and errors; i_lock_clr -> IDLE with retry cleared.
  - i_lock_clr outside LOCK: no effect.
  - Illegal state -> IDLE.
- o_pwm_en=1 only when next state is RUN.
- o_intb_n=0 when next state is FAULT/LOCK/IDLE, or any sticky bit is (or becomes) set; else 1.
- Report-only errors (kill=0) set sticky and pull intb low, but do not leave RUN.
- Reset mid-operation returns everything to reset values next edge, regardless of state.

Optional Feature:
- HV_FLT_MGR_SNAPSHOT_EN defined:
  - On every RUN->FAULT transition, with o_first_err==0, capture o_first_err <= act & i_err_kill.
  - Held until i_lock_clr, or until a retry-count clear in RUN.
  - Later faults do not overwrite it.
- Undefined: o_first_err tied to 0, no snapshot flops.

Test Plan:
- Debounce: reset, i_en=1; raw[0] 1 for 3 cycles then 0 -> flt/sticky stay 0, pwm stays 1. Raw[0] 1 held -> o_err_flt[0]=1 at edge 4, o_st=FAULT and o_pwm_en=0 one edge later, o_retry_cnt=1, o_intb_n=0.
- Recovery: kill=0xFF, raw[2] pulse 10 cycles -> FAULT. After raw released plus debounce: RCV for 16 cycles, then RUN, pwm=1. Clear sticky[2] -> intb_n=1. After 16 clean RUN cycles -> retry=0.
- Lockout: three kill faults, each separated by less than 16 clean cycles -> after third release o_st=LOCK, pwm=0. i_en toggle has no effect. i_lock_clr -> IDLE, retry=0, then RUN.
- Mask/class: mask[5]=1, raw[5]=1 -> no sticky, stays RUN. kill[6]=0, raw[6]=1 -> sticky[6]=1, intb_n=0, pwm stays 1. Simultaneous clr[6] while active -> sticky stays 1.
- Re-fault in RCV: raw[1] re-asserts mid-recovery -> FAULT, retry increments. ~i_en in RCV -> IDLE. i_rst mid-FAULT -> all reset values next edge.
- Snapshot (macro on): raw[3]&raw[4] together -> o_first_err=0x18. Later raw[0] fault -> unchanged. i_lock_clr -> 0. Macro off -> always 0.
